// File: rtl/msi_irq_scheduler.sv
// Round-robin MSI scheduler: latches per-source interrupt edges, maps each source to a
// granted MSI vector, coalesces sources that share a vector, and spaces messages apart.
module msi_irq_scheduler #(
   parameter int unsigned NUM_SRC   = 8,
   parameter int unsigned HOLDOFF   = 16,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC-1:0]   irq_src,
   input  logic [NUM_SRC-1:0]   irq_mask,
   input  logic                 msi_enable,
   input  logic [2:0]           msi_vector_width,
   output logic                 intx_msi_request,
   input  logic                 intx_msi_grant,
   output logic [4:0]           msi_vector_num,
   output logic [NUM_SRC-1:0]   pending,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] msi_sent_count
);

   localparam int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned HO_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam int unsigned HO_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLDOFF
   } state_t;

   state_t               state, nxt_state;
   logic [NUM_SRC-1:0]   prev;
   logic [NUM_SRC-1:0]   ev, elig, clr, nxt_pending;
   logic [PTR_W-1:0]     ptr, nxt_ptr, sel, nxt_sel;
   logic [HO_W-1:0]      ho_cnt, nxt_ho_cnt;
   logic                 nxt_request;
   logic [4:0]           nxt_vector, vmask;
   logic [CNT_WIDTH-1:0] nxt_count;
   logic                 pick_found;
   logic [PTR_W-1:0]     pick_idx;

   assign ev          = irq_src & ~prev;
   assign elig        = pending & ~irq_mask;
   assign nxt_pending = (pending & ~clr) | ev;

   // Vector mask from the host-granted vector count, capped at 32 vectors
   always_comb begin
      vmask = 5'h1f;
      case (msi_vector_width)
         3'd0:    vmask = 5'h00;
         3'd1:    vmask = 5'h01;
         3'd2:    vmask = 5'h03;
         3'd3:    vmask = 5'h07;
         3'd4:    vmask = 5'h0f;
         default: vmask = 5'h1f;
      endcase
   end

   // First eligible source at or after the round-robin pointer, wrapping
   always_comb begin
      int unsigned      idx;
      logic [PTR_W-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      cand       = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         cand = PTR_W'(idx);
         if (!pick_found && elig[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      nxt_state   = state;
      nxt_ptr     = ptr;
      nxt_sel     = sel;
      nxt_ho_cnt  = ho_cnt;
      nxt_request = intx_msi_request;
      nxt_vector  = msi_vector_num;
      nxt_count   = msi_sent_count;
      clr         = '0;
      case (state)
         S_IDLE: begin
            if (msi_enable && pick_found) begin
               nxt_sel     = pick_idx;
               nxt_vector  = 5'(pick_idx) & vmask;
               nxt_request = 1'b1;
               nxt_state   = S_REQ;
            end
         end
         S_REQ: begin
            if (intx_msi_grant) begin
               // Coalesce every eligible source that shares the vector being sent
               for (int unsigned j = 0; j < NUM_SRC; j++) begin
                  clr[j] = elig[j] && ((5'(j) & vmask) == msi_vector_num);
               end
               nxt_ptr     = (32'(sel) == NUM_SRC - 1) ? '0 : sel + PTR_W'(1);
               nxt_count   = msi_sent_count + CNT_WIDTH'(1);
               nxt_request = 1'b0;
               if (HOLDOFF > 0) begin
                  nxt_state  = S_HOLDOFF;
                  nxt_ho_cnt = HO_W'(HO_LOAD);
               end else begin
                  nxt_state = S_IDLE;
               end
            end
         end
         S_HOLDOFF: begin
            if (ho_cnt == '0) nxt_state = S_IDLE;
            else              nxt_ho_cnt = ho_cnt - HO_W'(1);
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         prev             <= '1;
         pending          <= '0;
         ptr              <= '0;
         sel              <= '0;
         ho_cnt           <= '0;
         intx_msi_request <= 1'b0;
         msi_vector_num   <= 5'd0;
         busy             <= 1'b0;
         msi_sent_count   <= '0;
      end else begin
         state            <= nxt_state;
         prev             <= irq_src;
         pending          <= nxt_pending;
         ptr              <= nxt_ptr;
         sel              <= nxt_sel;
         ho_cnt           <= nxt_ho_cnt;
         intx_msi_request <= nxt_request;
         msi_vector_num   <= nxt_vector;
         busy             <= (nxt_state != S_IDLE);
         msi_sent_count   <= nxt_count;
      end
   end

endmodule

// File: tb/tb_msi_irq_scheduler.sv
// Bench for msi_irq_scheduler: an event-level reference model checked every cycle,
// plus directed scenarios with hand-computed vectors, pending bits and timings.
module tb_msi_irq_scheduler;

   localparam int unsigned NUM_SRC   = 8;
   localparam int unsigned HOLDOFF   = 16;
   localparam int unsigned CNT_WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_SRC-1:0]   irq_src;
   logic [NUM_SRC-1:0]   irq_mask;
   logic                 msi_enable;
   logic [2:0]           msi_vector_width;
   logic                 intx_msi_request;
   logic                 intx_msi_grant;
   logic [4:0]           msi_vector_num;
   logic [NUM_SRC-1:0]   pending;
   logic                 busy;
   logic [CNT_WIDTH-1:0] msi_sent_count;

   always #5 clk = ~clk;

   msi_irq_scheduler #(
      .NUM_SRC   (NUM_SRC),
      .HOLDOFF   (HOLDOFF),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .irq_src          (irq_src),
      .irq_mask         (irq_mask),
      .msi_enable       (msi_enable),
      .msi_vector_width (msi_vector_width),
      .intx_msi_request (intx_msi_request),
      .intx_msi_grant   (intx_msi_grant),
      .msi_vector_num   (msi_vector_num),
      .pending          (pending),
      .busy             (busy),
      .msi_sent_count   (msi_sent_count)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_on  = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: sources, vectors and cooldown expressed as plain integers
   bit [NUM_SRC-1:0] m_pend, m_prev;
   int               m_ptr, m_sel, m_cool, m_vec, m_cnt;
   bit               m_req;

   function automatic int vec_of(input int src, input int width);
      int ew;
      ew = (width > 5) ? 5 : width;
      return src % (1 << ew);
   endfunction

   always @(posedge clk) begin : model
      bit [NUM_SRC-1:0] ev, elig, clr;
      int               w;
      if (rst) begin
         m_pend = '0;
         m_prev = '1;
         m_ptr  = 0;
         m_sel  = 0;
         m_cool = 0;
         m_vec  = 0;
         m_cnt  = 0;
         m_req  = 1'b0;
      end else begin
         w      = int'(msi_vector_width);
         ev     = irq_src & ~m_prev;
         m_prev = irq_src;
         elig   = m_pend & ~irq_mask;
         clr    = '0;
         if (m_req) begin
            if (intx_msi_grant) begin
               for (int j = 0; j < int'(NUM_SRC); j++)
                  if (elig[j] && vec_of(j, w) == m_vec) clr[j] = 1'b1;
               m_ptr  = (m_sel + 1) % int'(NUM_SRC);
               m_cnt  = m_cnt + 1;
               m_req  = 1'b0;
               m_cool = int'(HOLDOFF);
            end
         end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
         end else if (msi_enable && elig != '0) begin
            for (int k = 0; k < int'(NUM_SRC); k++) begin
               if (!m_req && elig[(m_ptr + k) % int'(NUM_SRC)]) begin
                  m_sel = (m_ptr + k) % int'(NUM_SRC);
                  m_vec = vec_of(m_sel, w);
                  m_req = 1'b1;
               end
            end
         end
         m_pend = (m_pend & ~clr) | ev;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         check("cyc_request", 32'(intx_msi_request), 32'(m_req));
         check("cyc_vector",  32'(msi_vector_num),   m_vec);
         check("cyc_pending", 32'(pending),          32'(m_pend));
         check("cyc_busy",    32'(busy),             32'(m_req || m_cool > 0));
         check("cyc_count",   32'(msi_sent_count),   m_cnt & 32'hffff);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [NUM_SRC-1:0] v);
      irq_src = v;
      step(1);
      irq_src = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
   endtask

   // Wait (bounded) for a request, check its vector, grant it for one cycle
   task automatic serve(input int exp_vec, input string name, output int waited);
      waited = 0;
      while (intx_msi_request !== 1'b1 && waited < 64) begin
         step(1);
         waited++;
      end
      if (intx_msi_request !== 1'b1) begin
         check({name, "_timeout"}, 32'(intx_msi_request), 32'd1);
      end else begin
         check({name, "_vec"}, 32'(msi_vector_num), exp_vec);
         intx_msi_grant = 1'b1;
         step(1);
         intx_msi_grant = 1'b0;
      end
   endtask

   initial begin
      int waited;
      rst              = 1'b1;
      irq_src          = '0;
      irq_mask         = '0;
      msi_enable       = 1'b1;
      msi_vector_width = 3'd3;
      intx_msi_grant   = 1'b0;
      step(2);
      cmp_on = 1'b1;
      check("rst_request", 32'(intx_msi_request), 32'd0);
      check("rst_busy",    32'(busy),             32'd0);
      check("rst_count",   32'(msi_sent_count),   32'd0);
      rst = 1'b0;
      step(1);

      // Single source: vector 5, two-cycle latency, 16 holdoff cycles
      pulse(8'h20);
      check("t1_pending",  32'(pending),          32'h20);
      check("t1_noreq",    32'(intx_msi_request), 32'd0);
      step(1);
      check("t1_request",  32'(intx_msi_request), 32'd1);
      check("t1_vector",   32'(msi_vector_num),   32'd5);
      step(2);
      intx_msi_grant = 1'b1;
      step(1);
      intx_msi_grant = 1'b0;
      check("t1_req_drop", 32'(intx_msi_request), 32'd0);
      check("t1_cleared",  32'(pending),          32'h00);
      check("t1_count",    32'(msi_sent_count),   32'd1);
      check("t1_busy",     32'(busy),             32'd1);
      step(15);
      check("t1_busy_end", 32'(busy),             32'd1);
      step(1);
      check("t1_idle",     32'(busy),             32'd0);

      // Round robin from pointer 0, then wrap from pointer 7
      do_reset();
      pulse(8'h4a);
      serve(1, "t2_a", waited);
      serve(3, "t2_b", waited);
      serve(6, "t2_c", waited);
      pulse(8'h42);
      serve(1, "t2_d", waited);
      serve(6, "t2_e", waited);
      pulse(8'h81);
      serve(7, "t2_f", waited);
      serve(0, "t2_g", waited);
      check("t2_count", 32'(msi_sent_count), 32'd7);

      // Coalescing with two vectors
      do_reset();
      msi_vector_width = 3'd1;
      pulse(8'h17);
      serve(0, "t3_a", waited);
      check("t3_pend_a", 32'(pending), 32'h02);
      serve(1, "t3_b", waited);
      check("t3_pend_b", 32'(pending), 32'h00);
      check("t3_count",  32'(msi_sent_count), 32'd2);

      // Enable gating, stray grant, masking
      msi_vector_width = 3'd3;
      do_reset();
      msi_enable = 1'b0;
      pulse(8'h04);
      step(4);
      check("t4_disabled_req",  32'(intx_msi_request), 32'd0);
      check("t4_disabled_pend", 32'(pending),          32'h04);
      intx_msi_grant = 1'b1;
      step(1);
      intx_msi_grant = 1'b0;
      check("t4_stray_grant",   32'(msi_sent_count),   32'd0);
      irq_mask   = 8'h04;
      msi_enable = 1'b1;
      step(4);
      check("t4_masked_req",    32'(intx_msi_request), 32'd0);
      irq_mask = 8'h00;
      step(1);
      check("t4_unmask_req",    32'(intx_msi_request), 32'd1);
      serve(2, "t4_serve", waited);

      // New edge on the source being granted survives the clear
      do_reset();
      pulse(8'h08);
      step(1);
      check("t5_request", 32'(intx_msi_request), 32'd1);
      intx_msi_grant = 1'b1;
      irq_src        = 8'h08;
      step(1);
      intx_msi_grant = 1'b0;
      irq_src        = 8'h00;
      check("t5_pending", 32'(pending), 32'h08);
      serve(3, "t5_second", waited);
      check("t5_wait", 32'(waited), 32'd17);
      check("t5_count", 32'(msi_sent_count), 32'd2);

      // Reset during a request, then a level held across reset release
      step(20);
      pulse(8'h10);
      step(1);
      check("t6_request", 32'(intx_msi_request), 32'd1);
      rst     = 1'b1;
      irq_src = 8'h01;
      step(1);
      check("t6_rst_req",  32'(intx_msi_request), 32'd0);
      check("t6_rst_pend", 32'(pending),          32'h00);
      step(1);
      rst = 1'b0;
      step(10);
      check("t6_held_req",  32'(intx_msi_request), 32'd0);
      check("t6_held_pend", 32'(pending),          32'h00);
      irq_src = 8'h00;
      step(2);

      cmp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
